// File: rtl/pred_weight_table_bank_pkg.sv
// Shared encodings, FSM states and denominator sizing for the weighted-prediction table.
package pred_weight_pkg;
  localparam logic [1:0] COMP_Y   = 2'd0;
  localparam logic [1:0] COMP_CB  = 2'd1;
  localparam logic [1:0] COMP_CR  = 2'd2;
  localparam logic [1:0] COMP_BAD = 2'd3;

  localparam int MAX_DENOM  = 7;
  localparam int DENOM_BITS = $clog2(MAX_DENOM + 1);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  function automatic logic [DENOM_BITS-1:0] comp_denom(
    input logic [1:0]            comp,
    input logic [DENOM_BITS-1:0] luma,
    input logic [DENOM_BITS-1:0] chroma
  );
    return (comp == COMP_CB || comp == COMP_CR) ? chroma : luma;
  endfunction
endpackage

// File: rtl/pred_weight_table_bank_if.sv
// Entry-write and lookup bus between the slice-header parser / weighted-sample stage and the table.
interface pred_weight_table_bank_if #(
  parameter int W_BITS   = 9,
  parameter int O_BITS   = 8,
  parameter int IDX_BITS = 4
);
  logic                       wr_valid;
  logic                       wr_list;
  logic [1:0]                 wr_comp;
  logic [IDX_BITS-1:0]        wr_idx;
  logic signed [W_BITS-1:0]   wr_weight;
  logic signed [O_BITS-1:0]   wr_offset;
  logic                       wr_err;

  logic                       rd_valid;
  logic                       rd_ready;
  logic [1:0]                 rd_comp;
  logic [4:0]                 rd_ref_l0;
  logic [4:0]                 rd_ref_l1;

  logic                       out_valid;
  logic [2:0]                 out_logwd;
  logic signed [W_BITS-1:0]   out_w0;
  logic signed [W_BITS-1:0]   out_w1;
  logic signed [O_BITS-1:0]   out_o0;
  logic signed [O_BITS-1:0]   out_o1;
  logic                       out_err;

  modport master (
    output wr_valid, wr_list, wr_comp, wr_idx, wr_weight, wr_offset,
    output rd_valid, rd_comp, rd_ref_l0, rd_ref_l1,
    input  wr_err, rd_ready,
    input  out_valid, out_logwd, out_w0, out_w1, out_o0, out_o1, out_err
  );

  modport slave (
    input  wr_valid, wr_list, wr_comp, wr_idx, wr_weight, wr_offset,
    input  rd_valid, rd_comp, rd_ref_l0, rd_ref_l1,
    output wr_err, rd_ready,
    output out_valid, out_logwd, out_w0, out_w1, out_o0, out_o1, out_err
  );
endinterface

// File: rtl/pred_weight_table_bank_list_bank.sv
// One reference list: 3 x NUM_REF weight/offset entries with valid flags,
// a write port and a combinational read port that substitutes the default entry.
module pwt_list_bank
  import pred_weight_pkg::*;
#(
  parameter int NUM_REF  = 16,
  parameter int W_BITS   = 9,
  parameter int O_BITS   = 8,
  parameter int IDX_BITS = $clog2(NUM_REF)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [1:0]               wr_comp,
  input  logic [IDX_BITS-1:0]      wr_idx,
  input  logic signed [W_BITS-1:0] wr_weight,
  input  logic signed [O_BITS-1:0] wr_offset,
  input  logic [1:0]               rd_comp,
  input  logic [IDX_BITS-1:0]      rd_idx,
  input  logic                     rd_in_range,
  input  logic [DENOM_BITS-1:0]    rd_denom,
  output logic signed [W_BITS-1:0] rd_weight,
  output logic signed [O_BITS-1:0] rd_offset
);
  logic signed [W_BITS-1:0] weight_mem [3][NUM_REF];
  logic signed [O_BITS-1:0] offset_mem [3][NUM_REF];
  logic [2:0][NUM_REF-1:0]  flags;
  logic                     hit;

  // Payload carries no reset: an entry is only ever read once its flag is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      weight_mem[wr_comp][wr_idx] <= wr_weight;
      offset_mem[wr_comp][wr_idx] <= wr_offset;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else if (clear) begin
      flags <= '0;
    end else if (wr_en) begin
      flags[wr_comp][wr_idx] <= 1'b1;
    end
  end

  always_comb begin
    hit       = rd_in_range && flags[rd_comp][rd_idx];
    rd_weight = W_BITS'(1) << rd_denom;
    rd_offset = '0;
    if (hit) begin
      rd_weight = weight_mem[rd_comp][rd_idx];
      rd_offset = offset_mem[rd_comp][rd_idx];
    end
  end
endmodule

// File: rtl/pred_weight_table_bank.sv
// Explicit weighted-prediction table: load FSM, write/lookup qualification,
// reference range check and the one-cycle lookup output register.
module pred_weight_table_bank
  import pred_weight_pkg::*;
#(
  parameter int NUM_REF  = 16,
  parameter int W_BITS   = 9,
  parameter int O_BITS   = 8,
  parameter int IDX_BITS = $clog2(NUM_REF)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   slice_start,
  input  logic [DENOM_BITS-1:0]  luma_denom,
  input  logic [DENOM_BITS-1:0]  chroma_denom,
  input  logic                   load_done,
  pred_weight_table_bank_if.slave bus
);
  state_t                   state;
  logic [DENOM_BITS-1:0]    luma_q, chroma_q;
  logic                     wr_acc, rd_acc, rd_bad, in_range0, in_range1;
  logic [1:0]               rd_comp_eff;
  logic [DENOM_BITS-1:0]    rd_denom;
  logic signed [W_BITS-1:0] w0, w1;
  logic signed [O_BITS-1:0] o0, o1;

  // slice_start wins over a coincident write, so the cleared table never sees it.
  assign wr_acc      = bus.wr_valid && (state == ST_LOADING) && !slice_start
                       && (bus.wr_comp != COMP_BAD);
  assign bus.rd_ready = (state == ST_READY);
  assign rd_acc      = bus.rd_valid && (state == ST_READY);
  assign rd_bad      = (bus.rd_comp == COMP_BAD);
  assign rd_comp_eff = rd_bad ? COMP_Y : bus.rd_comp;
  assign rd_denom    = comp_denom(rd_comp_eff, luma_q, chroma_q);
  assign in_range0   = 32'(bus.rd_ref_l0) < NUM_REF;
  assign in_range1   = 32'(bus.rd_ref_l1) < NUM_REF;

  pwt_list_bank #(.NUM_REF(NUM_REF), .W_BITS(W_BITS), .O_BITS(O_BITS), .IDX_BITS(IDX_BITS)) u_l0 (
    .clk(clk), .reset(reset), .clear(slice_start),
    .wr_en(wr_acc && !bus.wr_list), .wr_comp(bus.wr_comp), .wr_idx(bus.wr_idx),
    .wr_weight(bus.wr_weight), .wr_offset(bus.wr_offset),
    .rd_comp(rd_comp_eff), .rd_idx(bus.rd_ref_l0[IDX_BITS-1:0]), .rd_in_range(in_range0),
    .rd_denom(rd_denom), .rd_weight(w0), .rd_offset(o0)
  );

  pwt_list_bank #(.NUM_REF(NUM_REF), .W_BITS(W_BITS), .O_BITS(O_BITS), .IDX_BITS(IDX_BITS)) u_l1 (
    .clk(clk), .reset(reset), .clear(slice_start),
    .wr_en(wr_acc && bus.wr_list), .wr_comp(bus.wr_comp), .wr_idx(bus.wr_idx),
    .wr_weight(bus.wr_weight), .wr_offset(bus.wr_offset),
    .rd_comp(rd_comp_eff), .rd_idx(bus.rd_ref_l1[IDX_BITS-1:0]), .rd_in_range(in_range1),
    .rd_denom(rd_denom), .rd_weight(w1), .rd_offset(o1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      luma_q     <= '0;
      chroma_q   <= '0;
      bus.wr_err <= 1'b0;
    end else begin
      bus.wr_err <= bus.wr_valid && !wr_acc;
      if (slice_start) begin
        state    <= ST_LOADING;
        luma_q   <= luma_denom;
        chroma_q <= chroma_denom;
      end else if (load_done && state == ST_LOADING) begin
        state <= ST_READY;
      end
    end
  end

  // Results hold their last value between accepted lookups.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_logwd <= '0;
      bus.out_w0    <= '0;
      bus.out_w1    <= '0;
      bus.out_o0    <= '0;
      bus.out_o1    <= '0;
      bus.out_err   <= 1'b0;
    end else begin
      bus.out_valid <= rd_acc;
      if (rd_acc) begin
        bus.out_logwd <= rd_denom;
        bus.out_w0    <= w0;
        bus.out_w1    <= w1;
        bus.out_o0    <= o0;
        bus.out_o1    <= o1;
        bus.out_err   <= rd_bad || !in_range0 || !in_range1;
      end
    end
  end
endmodule

// File: tb/tb_pred_weight_table_bank.sv
// Bench for pred_weight_table_bank: directed vector table plus randomized traffic against a cycle model.
module tb_pred_weight_table_bank;
  localparam int NUM_REF  = 16;
  localparam int W_BITS   = 9;
  localparam int O_BITS   = 8;
  localparam int IDX_BITS = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       slice_start;
  logic [2:0] luma_denom, chroma_denom;
  logic       load_done;

  int tests = 0;
  int fails = 0;

  pred_weight_table_bank_if #(.W_BITS(W_BITS), .O_BITS(O_BITS), .IDX_BITS(IDX_BITS)) bus ();

  pred_weight_table_bank #(.NUM_REF(NUM_REF), .W_BITS(W_BITS), .O_BITS(O_BITS), .IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .reset(reset), .slice_start(slice_start), .luma_denom(luma_denom),
    .chroma_denom(chroma_denom), .load_done(load_done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: table contents as plain arrays, state as 0=empty 1=loading 2=ready.
  int mw [2][3][NUM_REF];
  int mo [2][3][NUM_REF];
  bit mf [2][3][NUM_REF];
  int m_state, m_luma, m_chroma;
  int e_valid, e_logwd, e_w0, e_o0, e_w1, e_o1, e_err, e_wr_err;

  typedef struct {
    int phase;
    int comp, r0, r1;
    int w0, o0, w1, o1, logwd, err;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (mf[a, b, i]) mf[a][b][i] = 1'b0;
    m_state = 0; m_luma = 0; m_chroma = 0;
    e_valid = 0; e_logwd = 0; e_w0 = 0; e_o0 = 0; e_w1 = 0; e_o1 = 0; e_err = 0; e_wr_err = 0;
  endtask

  task automatic idle();
    slice_start = 0; load_done = 0; luma_denom = 0; chroma_denom = 0;
    bus.wr_valid = 0; bus.wr_list = 0; bus.wr_comp = 0; bus.wr_idx = 0;
    bus.wr_weight = 0; bus.wr_offset = 0;
    bus.rd_valid = 0; bus.rd_comp = 0; bus.rd_ref_l0 = 0; bus.rd_ref_l1 = 0;
  endtask

  task automatic list_lookup(input int l, input int c, input int r, input int d,
                             output int w, output int o);
    if (r < NUM_REF && mf[l][c][r]) begin
      w = mw[l][c][r]; o = mo[l][c][r];
    end else begin
      w = 1 << d; o = 0;
    end
  endtask

  // Apply the current inputs for one clock and compare every output against the model.
  task automatic cycle();
    int c, d, r0, r1;
    bit acc, wacc;
    acc = bus.rd_valid && m_state == 2;
    if (acc) begin
      c  = (bus.rd_comp == 2'd3) ? 0 : int'(bus.rd_comp);
      d  = (c == 0) ? m_luma : m_chroma;
      r0 = int'(bus.rd_ref_l0);
      r1 = int'(bus.rd_ref_l1);
      e_logwd = d;
      e_err   = (bus.rd_comp == 2'd3 || r0 >= NUM_REF || r1 >= NUM_REF) ? 1 : 0;
      list_lookup(0, c, r0, d, e_w0, e_o0);
      list_lookup(1, c, r1, d, e_w1, e_o1);
    end
    e_valid  = acc ? 1 : 0;
    wacc     = bus.wr_valid && m_state == 1 && !slice_start && bus.wr_comp != 2'd3;
    e_wr_err = (bus.wr_valid && !wacc) ? 1 : 0;
    if (wacc) begin
      mw[bus.wr_list][bus.wr_comp][bus.wr_idx] = int'(bus.wr_weight);
      mo[bus.wr_list][bus.wr_comp][bus.wr_idx] = int'(bus.wr_offset);
      mf[bus.wr_list][bus.wr_comp][bus.wr_idx] = 1'b1;
    end
    if (slice_start) begin
      foreach (mf[a, b, i]) mf[a][b][i] = 1'b0;
      m_luma = int'(luma_denom); m_chroma = int'(chroma_denom); m_state = 1;
    end else if (load_done && m_state == 1) begin
      m_state = 2;
    end
    @(posedge clk); #1;
    check("out_valid", bus.out_valid, e_valid);
    check("wr_err", bus.wr_err, e_wr_err);
    check("rd_ready", bus.rd_ready, (m_state == 2) ? 1 : 0);
    check("out_logwd", bus.out_logwd, e_logwd);
    check("out_w0", bus.out_w0, e_w0);
    check("out_o0", bus.out_o0, e_o0);
    check("out_w1", bus.out_w1, e_w1);
    check("out_o1", bus.out_o1, e_o1);
    check("out_err", bus.out_err, e_err);
  endtask

  task automatic do_write(input int l, input int c, input int idx, input int w, input int o);
    bus.wr_valid = 1; bus.wr_list = l[0]; bus.wr_comp = c[1:0]; bus.wr_idx = idx[IDX_BITS-1:0];
    bus.wr_weight = W_BITS'(w); bus.wr_offset = O_BITS'(o);
    cycle();
    bus.wr_valid = 0;
  endtask

  task automatic start_slice(input int ld, input int cd);
    slice_start = 1; luma_denom = ld[2:0]; chroma_denom = cd[2:0];
    cycle();
    slice_start = 0;
  endtask

  task automatic finish_load();
    load_done = 1;
    cycle();
    load_done = 0;
  endtask

  task automatic run_vecs(input int phase);
    foreach (vecs[k]) begin
      if (vecs[k].phase == phase) begin
        bus.rd_valid = 1; bus.rd_comp = vecs[k].comp[1:0];
        bus.rd_ref_l0 = vecs[k].r0[4:0]; bus.rd_ref_l1 = vecs[k].r1[4:0];
        cycle();
        bus.rd_valid = 0;
        check($sformatf("vec%0d_w0", k), bus.out_w0, vecs[k].w0);
        check($sformatf("vec%0d_o0", k), bus.out_o0, vecs[k].o0);
        check($sformatf("vec%0d_w1", k), bus.out_w1, vecs[k].w1);
        check($sformatf("vec%0d_o1", k), bus.out_o1, vecs[k].o1);
        check($sformatf("vec%0d_logwd", k), bus.out_logwd, vecs[k].logwd);
        check($sformatf("vec%0d_err", k), bus.out_err, vecs[k].err);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // phase, comp, r0, r1, w0, o0, w1, o1, logwd, err  (luma denom 5, chroma denom 2)
    vecs.push_back('{0, 0,  0,  0,  32,  0,  32,  0, 5, 0});
    vecs.push_back('{1, 1,  3,  0,  -7, 12,   4,  0, 2, 0});
    vecs.push_back('{1, 0,  1,  0,  32,  0,  32,  0, 5, 0});
    vecs.push_back('{1, 0,  0,  5,  32,  0,  32,  0, 5, 0});
    vecs.push_back('{1, 2,  0,  5,   4,  0,   4,  0, 2, 0});
    vecs.push_back('{1, 0,  0,  7,  32,  0, 100, -5, 5, 0});
    vecs.push_back('{1, 0,  0, 16,  32,  0,  32,  0, 5, 1});
    vecs.push_back('{1, 3,  3,  0,  32,  0,  32,  0, 5, 1});
    vecs.push_back('{1, 1, 31,  7,   4,  0,   4,  0, 2, 1});

    idle();
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_ready", bus.rd_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_wr_err", bus.wr_err, 0);
    check("rst_out_w0", bus.out_w0, 0);
    check("rst_out_logwd", bus.out_logwd, 0);
    reset = 0;

    // Empty table: everything defaults.
    start_slice(5, 2);
    finish_load();
    run_vecs(0);

    // Loaded table with rejected writes mixed in.
    slice_start = 1; luma_denom = 5; chroma_denom = 2;
    do_write(0, 0, 1, 77, 3);
    slice_start = 0;
    do_write(0, 1, 3, -7, 12);
    do_write(1, 0, 7, 100, -5);
    do_write(1, 3, 5, 50, 9);
    finish_load();
    do_write(0, 0, 0, 99, 1);
    cycle();
    run_vecs(1);

    // Back-to-back lookups, then the same with slice_start on the fifth.
    for (int pass = 0; pass < 2; pass++) begin
      start_slice($urandom_range(0, 7), $urandom_range(0, 7));
      for (int i = 0; i < 30; i++)
        do_write($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, NUM_REF - 1),
                 $urandom_range(0, 511) - 256, $urandom_range(0, 255) - 128);
      finish_load();
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        bus.rd_valid = 1; bus.rd_comp = 2'($urandom_range(0, 2));
        bus.rd_ref_l0 = 5'(i); bus.rd_ref_l1 = 5'(15 - i);
        slice_start = (pass == 1 && i == 4); luma_denom = 3'd1; chroma_denom = 3'd6;
        cycle();
        if (bus.out_valid) cnt++;
      end
      idle();
      cycle();
      check(pass == 0 ? "b2b_count" : "b2b_slice_count", cnt, pass == 0 ? 8 : 5);
    end

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      slice_start  = ($urandom_range(0, 99) < 3);
      load_done    = ($urandom_range(0, 99) < 6);
      luma_denom   = 3'($urandom_range(0, 7));
      chroma_denom = 3'($urandom_range(0, 7));
      bus.wr_valid = $urandom_range(0, 1);
      bus.wr_list  = $urandom_range(0, 1);
      bus.wr_comp  = 2'($urandom_range(0, 3));
      bus.wr_idx   = IDX_BITS'($urandom_range(0, NUM_REF - 1));
      bus.wr_weight = W_BITS'($urandom);
      bus.wr_offset = O_BITS'($urandom);
      bus.rd_valid = ($urandom_range(0, 9) < 6);
      bus.rd_comp  = 2'($urandom_range(0, 3));
      bus.rd_ref_l0 = 5'($urandom_range(0, 9) < 8 ? $urandom_range(0, NUM_REF - 1) : $urandom_range(0, 31));
      bus.rd_ref_l1 = 5'($urandom_range(0, 9) < 8 ? $urandom_range(0, NUM_REF - 1) : $urandom_range(0, 31));
      cycle();
    end
    idle();
    cycle();

    // Reset while LOADING with a result still valid.
    start_slice(3, 4);
    finish_load();
    bus.rd_valid = 1; bus.rd_ref_l0 = 2; bus.rd_ref_l1 = 20;
    slice_start = 1; luma_denom = 3'd2;
    cycle();
    idle();
    check("pre_rst_out_valid", bus.out_valid, 1);
    #2 reset = 1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_err", bus.out_err, 0);
    check("mid_rst_out_w1", bus.out_w1, 0);
    check("mid_rst_out_logwd", bus.out_logwd, 0);
    check("mid_rst_rd_ready", bus.rd_ready, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    bus.rd_valid = 1;
    cycle();
    bus.rd_valid = 0;
    do_write(0, 0, 0, 5, 5);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
